// File: rtl/dlx_decode.sv
// DLX instruction decode stage: field decode, 32x32 register file with writeback
// bypass, registered execute operands/control, and a one-cycle load-use bubble.
module dlx_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] instr_in,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic [31:0] src1,
   output logic [31:0] src2,
   output logic [31:0] imm,
   output logic [6:0]  control_out,
   output logic        enable_ex,
   output logic [4:0]  dest_out,
   output logic        stall,
   output logic        illegal
);

   localparam logic [2:0] OPS_SHIFT     = 3'b000;
   localparam logic [2:0] OPS_ARITH     = 3'b001;
   localparam logic [2:0] OPS_MEM_WRITE = 3'b100;
   localparam logic [2:0] OPS_MEM_READ  = 3'b101;

   localparam logic [5:0] OPC_LW = 6'b100011;
   localparam logic [5:0] OPC_SW = 6'b101011;

   logic [31:0] rf [32];

   logic [5:0]  opc;
   logic [4:0]  rs1, rs2, rd_r;
   logic [31:0] simm;

   logic [6:0]  dec_ctrl;
   logic [31:0] dec_imm;
   logic [4:0]  dec_dest;
   logic        dec_ill;
   logic        dec_lw;
   logic        use1, use2;

   logic [31:0] rd1, rd2;
   logic        ld_pending;
   logic [4:0]  ld_dest;
   logic        hazard;
   logic        wb_fire;

   assign opc  = instr_in[31:26];
   assign rs1  = instr_in[25:21];
   assign rs2  = instr_in[20:16];
   assign rd_r = instr_in[15:11];
   assign simm = {{16{instr_in[15]}}, instr_in[15:0]};

   assign wb_fire = wb_en && (wb_addr != 5'd0);

   always_comb begin
      dec_ctrl = '0;
      dec_imm  = '0;
      dec_dest = '0;
      dec_ill  = 1'b0;
      dec_lw   = 1'b0;
      use1     = 1'b0;
      use2     = 1'b0;
      casez (opc)
         6'b000000: begin
            dec_ctrl = {instr_in[6:4], 1'b0, instr_in[2:0]};
            dec_dest = rd_r;
            use1     = 1'b1;
            use2     = 1'b1;
            if (instr_in[2:0] != OPS_SHIFT && instr_in[2:0] != OPS_ARITH)
               dec_ill = 1'b1;
            if (instr_in[2:0] == OPS_SHIFT && instr_in[6])
               dec_ill = 1'b1;
         end
         6'b001???: begin
            dec_ctrl = {opc[2:0], 1'b1, OPS_ARITH};
            dec_imm  = simm;
            dec_dest = rs2;
            use1     = 1'b1;
         end
         6'b0100??: begin
            dec_ctrl = {1'b0, opc[1:0], 1'b1, OPS_SHIFT};
            dec_imm  = {27'd0, instr_in[4:0]};
            dec_dest = rs2;
            use1     = 1'b1;
         end
         OPC_LW: begin
            dec_ctrl = {3'b000, 1'b1, OPS_MEM_READ};
            dec_imm  = simm;
            dec_dest = rs2;
            dec_lw   = 1'b1;
            use1     = 1'b1;
         end
         OPC_SW: begin
            dec_ctrl = {3'b000, 1'b1, OPS_MEM_WRITE};
            dec_imm  = simm;
            use1     = 1'b1;
            use2     = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // Reads bypass the writeback port so decode sees a value being written this cycle.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1 != 5'd0)
         rd1 = (wb_fire && wb_addr == rs1) ? wb_data : rf[rs1];
      if (rs2 != 5'd0)
         rd2 = (wb_fire && wb_addr == rs2) ? wb_data : rf[rs2];
   end

   assign hazard = instr_valid && ld_pending && (ld_dest != 5'd0) &&
                   ((use1 && rs1 == ld_dest) || (use2 && rs2 == ld_dest));
   assign stall  = hazard;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (wb_fire) begin
         rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src1        <= '0;
         src2        <= '0;
         imm         <= '0;
         control_out <= '0;
         enable_ex   <= 1'b0;
         dest_out    <= '0;
         illegal     <= 1'b0;
         ld_pending  <= 1'b0;
         ld_dest     <= '0;
      end else if (!instr_valid || hazard) begin
         control_out <= '0;
         enable_ex   <= 1'b0;
         dest_out    <= '0;
         ld_pending  <= 1'b0;
      end else if (dec_ill) begin
         control_out <= '0;
         enable_ex   <= 1'b0;
         dest_out    <= '0;
         illegal     <= 1'b1;
         ld_pending  <= 1'b0;
      end else begin
         src1        <= rd1;
         src2        <= rd2;
         imm         <= dec_imm;
         control_out <= dec_ctrl;
         enable_ex   <= 1'b1;
         dest_out    <= dec_dest;
         illegal     <= 1'b0;
         ld_pending  <= dec_lw;
         ld_dest     <= dec_dest;
      end
   end

endmodule
